// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - display ownership arbiter between operational and setup controllers
//
// Ports:
//   clk                     system clock, all state on the rising edge
//   rst                     asynchronous active-low reset
//   req_o, req_s            level requests from operational / setup controllers
//   pkt_o_in, pkt_s_in      6-digit BCD packets (digit 0 in bits [3:0])
//   ack_o, ack_s            registered ownership flags
//   enable_o, enable_s      display enables, identical to the acks
//   bcd_packet_operacional  registered operational packet
//   bcd_packet_setup        registered setup packet
//   busy                    registered, high whenever the arbiter is not idle

module display_arbiter #(
  parameter int MIN_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_o,
  input  logic            req_s,
  input  logic [5:0][3:0] pkt_o_in,
  input  logic [5:0][3:0] pkt_s_in,
  output logic            ack_o,
  output logic            ack_s,
  output logic            enable_o,
  output logic            enable_s,
  output logic [5:0][3:0] bcd_packet_operacional,
  output logic [5:0][3:0] bcd_packet_setup,
  output logic            busy
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [23:0]      BLANK_PKT = 24'hBBBBBB;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_O = 2'd1,
    GNT_S = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             tgt_s;      // owner the current gap hands over to: 1 = setup, 0 = operational
  logic             tgt_s_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             hold_met;
  logic             stay_granted;

  // Counter holds the index of the current grant cycle, so the grant has
  // lasted MIN_HOLD cycles once it reaches MIN_HOLD-1.
  assign hold_met = (cnt >= HOLD_LAST);

  always_comb begin
    state_nxt = state;
    tgt_s_nxt = tgt_s;
    case (state)
      IDLE: begin
        // Setup wins ties.
        if (req_s) begin
          state_nxt = GNT_S;
        end else if (req_o) begin
          state_nxt = GNT_O;
        end
      end
      GNT_O: begin
        // Release ignores the hold time; preemption honours it.
        if (!req_o) begin
          state_nxt = IDLE;
        end else if (req_s && hold_met) begin
          state_nxt = GAP;
          tgt_s_nxt = 1'b1;
        end
      end
      GNT_S: begin
        // Setup is never preempted while it still requests, so the hold
        // time never gates its hand-over.
        if (!req_s) begin
          if (req_o) begin
            state_nxt = GAP;
            tgt_s_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      GAP: begin
        // The blank cycle re-examines requests: the target may have
        // given up, in which case the other side may still take over.
        if (tgt_s) begin
          if (req_s) begin
            state_nxt = GNT_S;
          end else if (req_o) begin
            state_nxt = GNT_O;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          if (req_o) begin
            state_nxt = GNT_O;
          end else if (req_s) begin
            state_nxt = GNT_S;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Counting only continues inside an unbroken grant; every other
  // transition (entry, gap, idle) restarts it from zero.
  assign stay_granted = ((state == GNT_O) && (state_nxt == GNT_O)) ||
                        ((state == GNT_S) && (state_nxt == GNT_S));

  always_comb begin
    cnt_nxt = '0;
    if (stay_granted) begin
      cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end
  end

  // Outputs are registered from the next state so the enable and the
  // packet it qualifies change on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                  <= IDLE;
      tgt_s                  <= 1'b0;
      cnt                    <= '0;
      ack_o                  <= 1'b0;
      ack_s                  <= 1'b0;
      busy                   <= 1'b0;
      bcd_packet_operacional <= BLANK_PKT;
      bcd_packet_setup       <= BLANK_PKT;
    end else begin
      state <= state_nxt;
      tgt_s <= tgt_s_nxt;
      cnt   <= cnt_nxt;
      ack_o <= (state_nxt == GNT_O);
      ack_s <= (state_nxt == GNT_S);
      busy  <= (state_nxt != IDLE);
      // The non-owner's packet is left untouched so it keeps its last value.
      if (state_nxt == GNT_O) begin
        bcd_packet_operacional <= pkt_o_in;
      end
      if (state_nxt == GNT_S) begin
        bcd_packet_setup <= pkt_s_in;
      end
    end
  end

  assign enable_o = ack_o;
  assign enable_s = ack_s;

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - randomized and directed bench for display_arbiter

module tb_display_arbiter;

  localparam logic [23:0] BLANK = 24'hBBBBBB;

  logic            clk;
  logic            rst;
  logic            req_o;
  logic            req_s;
  logic [5:0][3:0] pkt_o;
  logic [5:0][3:0] pkt_s;

  logic            ack_o_w [2];
  logic            ack_s_w [2];
  logic            en_o_w  [2];
  logic            en_s_w  [2];
  logic            busy_w  [2];
  logic [5:0][3:0] pko_w   [2];
  logic [5:0][3:0] pks_w   [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Instance 0 uses MIN_HOLD=4, instance 1 uses MIN_HOLD=1.
  int hold_of [2] = '{4, 1};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    display_arbiter #(
      .MIN_HOLD((g == 0) ? 4 : 1),
      .CNT_W   (8)
    ) u_dut (
      .clk                    (clk),
      .rst                    (rst),
      .req_o                  (req_o),
      .req_s                  (req_s),
      .pkt_o_in               (pkt_o),
      .pkt_s_in               (pkt_s),
      .ack_o                  (ack_o_w[g]),
      .ack_s                  (ack_s_w[g]),
      .enable_o               (en_o_w[g]),
      .enable_s               (en_s_w[g]),
      .bcd_packet_operacional (pko_w[g]),
      .bcd_packet_setup       (pks_w[g]),
      .busy                   (busy_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner 0 = nobody, 1 = operational, 2 = setup, 3 = blank gap.
  int          m_own [2];
  int          m_age [2];
  int          m_tgt [2];
  logic [23:0] m_po  [2];
  logic [23:0] m_ps  [2];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_own[i] = 0;
      m_age[i] = 0;
      m_tgt[i] = 0;
      m_po[i]  = BLANK;
      m_ps[i]  = BLANK;
    end
  endtask

  task automatic m_step(int i);
    int nxt;
    nxt = m_own[i];
    case (m_own[i])
      0: begin
        if (req_s) nxt = 2;
        else if (req_o) nxt = 1;
      end
      1: begin
        if (!req_o) nxt = 0;
        else if (req_s && (m_age[i] + 1 >= hold_of[i])) begin
          nxt = 3;
          m_tgt[i] = 2;
        end
      end
      2: begin
        if (!req_s) begin
          if (req_o) begin
            nxt = 3;
            m_tgt[i] = 1;
          end else begin
            nxt = 0;
          end
        end
      end
      default: begin
        if (m_tgt[i] == 2) nxt = req_s ? 2 : (req_o ? 1 : 0);
        else nxt = req_o ? 1 : (req_s ? 2 : 0);
      end
    endcase
    if (nxt == m_own[i]) m_age[i]++;
    else m_age[i] = 0;
    m_own[i] = nxt;
    if (nxt == 1) m_po[i] = pkt_o;
    if (nxt == 2) m_ps[i] = pkt_s;
  endtask

  task automatic cmp_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("ctl%0d", i),
            {27'd0, ack_o_w[i], ack_s_w[i], en_o_w[i], en_s_w[i], busy_w[i]},
            {27'd0, m_own[i] == 1, m_own[i] == 2, m_own[i] == 1, m_own[i] == 2, m_own[i] != 0});
      check($sformatf("pkt_o%0d", i), {8'd0, pko_w[i]}, {8'd0, m_po[i]});
      check($sformatf("pkt_s%0d", i), {8'd0, pks_w[i]}, {8'd0, m_ps[i]});
    end
  endtask

  // Starts and ends just after a falling edge.
  task automatic cyc(bit ro, bit rs, logic [23:0] po, logic [23:0] ps);
    req_o = ro;
    req_s = rs;
    pkt_o = po;
    pkt_s = ps;
    @(posedge clk);
    for (int i = 0; i < 2; i++) m_step(i);
    #1;
    cmp_all();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #1;
    rst = 1'b0;
    #1;
    m_reset();
    cmp_all();
    rst = 1'b1;
  endtask

  initial begin
    bit ro;
    bit rs;
    rst   = 1'b0;
    req_o = 1'b1;
    req_s = 1'b0;
    pkt_o = 24'h123456;
    pkt_s = 24'h654321;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    cmp_all();
    check("rst_en_o", {31'd0, en_o_w[0]}, 32'd0);
    check("rst_pko", {8'd0, pko_w[0]}, {8'd0, BLANK});
    @(negedge clk);
    rst = 1'b1;

    // Release: operational granted on the first edge with the sampled packet.
    cyc(1, 0, 24'h987012, 24'h111111);
    check("rel_en_o", {31'd0, en_o_w[0]}, 32'd1);
    check("rel_pko", {8'd0, pko_w[0]}, 32'h00987012);
    cyc(0, 0, 24'h0, 24'h0);
    cyc(0, 0, 24'h0, 24'h0);

    // Simultaneous requests go to setup; release hands over through a gap.
    cyc(1, 1, 24'h222222, 24'h333333);
    check("sim_ack_s", {30'd0, ack_o_w[0], ack_s_w[0]}, 32'b01);
    cyc(1, 0, 24'h222222, 24'h333333);
    check("sim_gap", {30'd0, en_o_w[0], en_s_w[0]}, 32'b00);
    check("sim_gap_busy", {31'd0, busy_w[0]}, 32'd1);
    cyc(1, 0, 24'h222222, 24'h333333);
    check("sim_ack_o", {30'd0, ack_o_w[0], ack_s_w[0]}, 32'b10);
    cyc(0, 0, 24'h0, 24'h0);
    cyc(0, 0, 24'h0, 24'h0);

    // Minimum hold: operational granted at cycle 0, setup requests from cycle 1.
    cyc(1, 0, 24'h444444, 24'h555555);
    check("mh_c0", {31'd0, ack_o_w[0]}, 32'd1);
    cyc(1, 1, 24'h444444, 24'h555555);
    check("mh_c1", {31'd0, ack_o_w[0]}, 32'd1);
    check("mh1_c1_gap", {30'd0, ack_o_w[1], ack_s_w[1]}, 32'b00);
    cyc(1, 1, 24'h444444, 24'h555555);
    check("mh1_c2_s", {31'd0, ack_s_w[1]}, 32'd1);
    cyc(1, 1, 24'h444444, 24'h555555);
    check("mh_c3", {31'd0, ack_o_w[0]}, 32'd1);
    cyc(1, 1, 24'h444444, 24'h555555);
    check("mh_c4_gap", {30'd0, ack_o_w[0], ack_s_w[0]}, 32'b00);
    cyc(1, 1, 24'h444444, 24'h555555);
    check("mh_c5_s", {30'd0, ack_o_w[0], ack_s_w[0]}, 32'b01);

    // Setup is never preempted while it keeps requesting.
    for (int k = 0; k < 20; k++) begin
      cyc(1, 1, 24'h666666, 24'h777777);
      check("nopre_o", {31'd0, ack_o_w[0]}, 32'd0);
    end
    cyc(1, 0, 24'h654321, 24'h777777);
    check("nopre_gap", {31'd0, ack_s_w[0]}, 32'd0);
    cyc(1, 0, 24'h654321, 24'h777777);
    check("nopre_ack_o", {31'd0, ack_o_w[0]}, 32'd1);

    // Data tracking while operational owns; setup packet keeps its last value.
    check("dt_pko0", {8'd0, pko_w[0]}, 32'h00654321);
    cyc(1, 0, 24'hAAAAAA, 24'h888888);
    check("dt_pko1", {8'd0, pko_w[0]}, 32'h00AAAAAA);
    check("dt_pks", {8'd0, pks_w[0]}, 32'h00777777);

    // Abort in a gap targeting setup: operational takes the display back.
    cyc(1, 1, 24'hAAAAAA, 24'h888888);
    cyc(1, 1, 24'hAAAAAA, 24'h888888);
    cyc(1, 1, 24'hAAAAAA, 24'h888888);
    check("ab_gap", {30'd0, ack_o_w[0], ack_s_w[0]}, 32'b00);
    cyc(1, 0, 24'h121212, 24'h888888);
    check("ab_back_o", {31'd0, ack_o_w[0]}, 32'd1);
    repeat (3) cyc(1, 1, 24'h121212, 24'h888888);
    check("ab_gap2", {31'd0, busy_w[0]}, 32'd1);
    cyc(0, 0, 24'h0, 24'h0);
    check("ab_idle", {31'd0, busy_w[0]}, 32'd0);

    // Mid-grant asynchronous reset.
    cyc(1, 0, 24'h343434, 24'h0);
    pulse_reset();
    check("ar_en_o", {31'd0, en_o_w[0]}, 32'd0);
    cyc(1, 0, 24'h565656, 24'h0);

    // Randomized traffic with long-ish request levels.
    ro = 1'b0;
    rs = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 5) == 0) ro = ~ro;
      if ($urandom_range(0, 7) == 0) rs = ~rs;
      if ($urandom_range(0, 299) == 0) pulse_reset();
      cyc(ro, rs, 24'($urandom()), 24'($urandom()));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
